// File: rtl/monitor_secuencia.sv
// monitor_secuencia: learns the repeating 4-bit code sequence produced by the
// upstream counter/converter, then checks that it keeps repeating.
// Outputs: measured period, a lock flag and a one-cycle error pulse.
// Optional: define MONITOR_SECUENCIA_ERRCNT_EN to add the saturating ContErr
// counter of error pulses.
//
// state  | meaning
// IDLE   | nothing sampled since reset; next sample becomes the anchor
// LEARN  | storing samples into hist until the anchor value reappears
// VERIFY | period known, checking samples against hist, not yet locked
// LOCKED | one full period confirmed, still checking every sample
module monitor_secuencia #(
  parameter int MAXP = 16,
  parameter int ERRW = 8
) (
  input  logic            C,
  input  logic            nR,
  input  logic            En,
  input  logic [3:0]      D,
  output logic [4:0]      Periodo,
  output logic            Bloqueado,
  output logic            Error
`ifdef MONITOR_SECUENCIA_ERRCNT_EN
  ,
  output logic [ERRW-1:0] ContErr
`endif
);

  localparam int IW = (MAXP > 1) ? $clog2(MAXP) : 1;
  localparam logic [4:0] MAXP5 = 5'(MAXP);

  if (MAXP < 1 || MAXP > 16) begin : g_bad_maxp
    $error("monitor_secuencia: MAXP must be 1..16");
  end
  if (ERRW < 1) begin : g_bad_errw
    $error("monitor_secuencia: ERRW must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LEARN  = 2'd1,
    VERIFY = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      ancla, ancla_nx;
  logic [4:0]      ptr, ptr_nx;
  logic [4:0]      idx, idx_nx;
  logic [4:0]      periodo_nx;
  logic            bloq_nx;
  logic            error_nx;
  logic [3:0]      hist [MAXP];
  logic            hist_we;
  logic [IW-1:0]   hist_wa;
  logic [4:0]      idx_inc;
  logic [4:0]      idx_wrap;
  logic            hit;

  // state and control registers, all cleared asynchronously
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state     <= IDLE;
      ancla     <= 4'd0;
      ptr       <= 5'd0;
      idx       <= 5'd0;
      Periodo   <= 5'd0;
      Bloqueado <= 1'b0;
      Error     <= 1'b0;
    end else begin
      state     <= state_nx;
      ancla     <= ancla_nx;
      ptr       <= ptr_nx;
      idx       <= idx_nx;
      Periodo   <= periodo_nx;
      Bloqueado <= bloq_nx;
      Error     <= error_nx;
    end
  end

  // history buffer; contents are meaningless after reset so it has no reset
  always_ff @(posedge C) begin
    if (hist_we) begin
      hist[hist_wa] <= D;
    end
  end

  // next-state and output decode for one sample edge
  always_comb begin
    state_nx   = state;
    ancla_nx   = ancla;
    ptr_nx     = ptr;
    idx_nx     = idx;
    periodo_nx = Periodo;
    bloq_nx    = Bloqueado;
    error_nx   = 1'b0;
    hist_we    = 1'b0;
    hist_wa    = '0;
    idx_inc    = idx + 5'd1;
    idx_wrap   = (idx_inc == Periodo) ? 5'd0 : idx_inc;
    hit        = (D == hist[idx[IW-1:0]]);

    if (En) begin
      case (state)
        IDLE: begin
          ancla_nx = D;
          hist_we  = 1'b1;
          hist_wa  = '0;
          ptr_nx   = 5'd1;
          state_nx = LEARN;
        end

        LEARN: begin
          if (D == ancla) begin
            // anchor seen again: ptr samples form one period; hist[0] was just
            // matched, so the next expected word is hist[1] (or hist[0] if P=1)
            periodo_nx = ptr;
            idx_nx     = (ptr == 5'd1) ? 5'd0 : 5'd1;
            state_nx   = VERIFY;
          end else if (ptr == MAXP5) begin
            error_nx = 1'b1;
            ancla_nx = D;
            hist_we  = 1'b1;
            hist_wa  = '0;
            ptr_nx   = 5'd1;
          end else begin
            hist_we = 1'b1;
            hist_wa = ptr[IW-1:0];
            ptr_nx  = ptr + 5'd1;
          end
        end

        VERIFY, LOCKED: begin
          if (hit) begin
            idx_nx = idx_wrap;
            // lock once the anchor position itself is matched again, i.e.
            // a whole period has been re-observed after the period was measured
            if (state == VERIFY && idx == 5'd0) begin
              state_nx = LOCKED;
              bloq_nx  = 1'b1;
            end
          end else begin
            // mismatching word becomes the anchor of a fresh learn pass
            error_nx   = 1'b1;
            bloq_nx    = 1'b0;
            periodo_nx = 5'd0;
            ancla_nx   = D;
            hist_we    = 1'b1;
            hist_wa    = '0;
            ptr_nx     = 5'd1;
            state_nx   = LEARN;
          end
        end

        default: begin
          state_nx = IDLE;
        end
      endcase
    end
  end

`ifdef MONITOR_SECUENCIA_ERRCNT_EN
  // saturating count of error pulses, cleared only by reset
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      ContErr <= '0;
    end else if (error_nx && (ContErr != {ERRW{1'b1}})) begin
      ContErr <= ContErr + 1'b1;
    end
  end
`endif

endmodule
